// File: rtl/sincos_sweep_ctrl.sv
// Sweep sequencer for the pipelined sincos core: issues one angle per cycle,
// tags each issue through the core latency and returns indexed sin/cos samples.
module sincos_sweep_ctrl #(
    parameter int ANGLE_W = 10,
    parameter int OUT_W   = 5,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 11
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic [ANGLE_W-1:0] start_angle,
    input  logic [ANGLE_W-1:0] step,
    input  logic [CNT_W-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic [ANGLE_W-1:0] angle_out,
    input  logic [OUT_W-1:0]   sin_in,
    input  logic [OUT_W-1:0]   cos_in,
    output logic               sample_valid,
    output logic [OUT_W-1:0]   sample_sin,
    output logic [OUT_W-1:0]   sample_cos,
    output logic [CNT_W-1:0]   sample_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q;
    logic [ANGLE_W-1:0] angle_q, step_q, start_angle_q;
    logic [CNT_W-1:0]   count_q, issue_cnt_q;
    logic [LATENCY:0]   tag_v_q;
    logic [CNT_W-1:0]   tag_idx_q [LATENCY+1];
    logic               busy_q, done_q, sample_valid_q;
    logic [OUT_W-1:0]   sample_sin_q, sample_cos_q;
    logic [CNT_W-1:0]   sample_idx_q;

    logic               issue_d, last_issue_d, pipe_empty_d;
    logic [ANGLE_W-1:0] angle_d;

    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        issue_d      = 1'b0;
        angle_d      = angle_q;
        last_issue_d = 1'b0;
        pipe_empty_d = ~|tag_v_q;
        if (state_q == RUN && !pause && !abort) begin
            issue_d      = 1'b1;
            angle_d      = (issue_cnt_q == '0) ? start_angle_q : angle_q + step_q;
            last_issue_d = (issue_cnt_q == count_q - CNT_W'(1));
        end
    end

    // NOTE: all state uses non-blocking assignments; later assignments in this block
    // (abort handling) intentionally override the default shift/update above them.
    always_ff @(posedge clk) begin
        if (!areset) begin
            state_q        <= IDLE;
            angle_q        <= '0;
            step_q         <= '0;
            start_angle_q  <= '0;
            count_q        <= '0;
            issue_cnt_q    <= '0;
            tag_v_q        <= '0;
            // NOTE: the tag pipe is tiny and must not leak stale indices, so it is reset explicitly.
            for (int i = 0; i <= LATENCY; i++) tag_idx_q[i] <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_sin_q   <= '0;
            sample_cos_q   <= '0;
            sample_idx_q   <= '0;
        end else begin
            done_q       <= 1'b0;
            tag_v_q      <= {tag_v_q[LATENCY-1:0], issue_d};
            tag_idx_q[0] <= issue_cnt_q;
            for (int i = 1; i <= LATENCY; i++) tag_idx_q[i] <= tag_idx_q[i-1];

            // The tag leaving the last stage lines up with the core result on sin_in/cos_in.
            sample_valid_q <= tag_v_q[LATENCY];
            if (tag_v_q[LATENCY]) begin
                sample_sin_q <= sin_in;
                sample_cos_q <= cos_in;
                sample_idx_q <= tag_idx_q[LATENCY];
            end

            if (issue_d) begin
                angle_q     <= angle_d;
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (count != '0) begin
                            start_angle_q <= start_angle;
                            step_q        <= step;
                            count_q       <= count;
                            issue_cnt_q   <= '0;
                            state_q       <= RUN;
                            busy_q        <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_d && last_issue_d) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!abort && pipe_empty_d) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (abort && state_q != IDLE) begin
                state_q        <= IDLE;
                busy_q         <= 1'b0;
                tag_v_q        <= '0;
                sample_valid_q <= 1'b0;
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign angle_out    = angle_q;
    assign sample_valid = sample_valid_q;
    assign sample_sin   = sample_sin_q;
    assign sample_cos   = sample_cos_q;
    assign sample_idx   = sample_idx_q;

endmodule

// File: tb/tb_sincos_sweep_ctrl.sv
// Directed bench for sincos_sweep_ctrl with a 2-stage behavioural sincos core model.
module tb_sincos_sweep_ctrl;

    localparam int ANGLE_W = 10;
    localparam int OUT_W   = 5;
    localparam int LATENCY = 2;
    localparam int CNT_W   = 11;

    logic               clk = 1'b0;
    logic               areset, start, abort, pause;
    logic [ANGLE_W-1:0] start_angle, step;
    logic [CNT_W-1:0]   count;
    logic               busy, done, sample_valid;
    logic [ANGLE_W-1:0] angle_out;
    logic [OUT_W-1:0]   sin_in, cos_in, sample_sin, sample_cos;
    logic [CNT_W-1:0]   sample_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct {
        int idx;
        int s;
        int c;
        int cyc;
    } smp_t;
    smp_t smp_q[$];

    sincos_sweep_ctrl #(
        .ANGLE_W(ANGLE_W), .OUT_W(OUT_W), .LATENCY(LATENCY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .areset(areset), .start(start), .abort(abort), .pause(pause),
        .start_angle(start_angle), .step(step), .count(count),
        .busy(busy), .done(done), .angle_out(angle_out),
        .sin_in(sin_in), .cos_in(cos_in),
        .sample_valid(sample_valid), .sample_sin(sample_sin),
        .sample_cos(sample_cos), .sample_idx(sample_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] f_s(input logic [ANGLE_W-1:0] a);
        return a[4:0] ^ a[9:5];
    endfunction

    function automatic logic [OUT_W-1:0] f_c(input logic [ANGLE_W-1:0] a);
        return a[9:5] + a[4:0];
    endfunction

    // Core model: result for the angle updated at edge t appears after edge t+LATENCY.
    logic [OUT_W-1:0] core_s [LATENCY];
    logic [OUT_W-1:0] core_c [LATENCY];
    initial for (int i = 0; i < LATENCY; i++) begin core_s[i] = '0; core_c[i] = '0; end
    always @(posedge clk) begin
        core_s[0] <= f_s(angle_out);
        core_c[0] <= f_c(angle_out);
        for (int i = 1; i < LATENCY; i++) begin
            core_s[i] <= core_s[i-1];
            core_c[i] <= core_c[i-1];
        end
    end
    assign sin_in = core_s[LATENCY-1];
    assign cos_in = core_c[LATENCY-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sample_valid)
            smp_q.push_back('{idx: int'(sample_idx), s: int'(sample_sin),
                              c: int'(sample_cos), cyc: cyc});
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output int dcyc);
        int k;
        k = 0;
        while (done !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        check("done_seen", done, 1);
        dcyc = cyc;
    endtask

    task automatic kick(input logic [ANGLE_W-1:0] sa, input logic [ANGLE_W-1:0] st,
                        input logic [CNT_W-1:0] n);
        start_angle = sa;
        step        = st;
        count       = n;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic run_sweep(input string name, input logic [ANGLE_W-1:0] sa,
                             input logic [ANGLE_W-1:0] st, input int n, input int exp_ang[4]);
        int s0, dcyc;
        smp_q.delete();
        kick(sa, st, CNT_W'(n));
        s0 = cyc;
        check({name, "_busy_start"}, busy, 1);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s_angle%0d", name, i), angle_out, exp_ang[i]);
        end
        wait_done(20, dcyc);
        check({name, "_done_cyc"}, dcyc - s0, n + 4);
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_nsamples"}, smp_q.size(), n);
        for (int i = 0; i < n && i < smp_q.size(); i++) begin
            check($sformatf("%s_idx%0d", name, i), smp_q[i].idx, i);
            check($sformatf("%s_sin%0d", name, i), smp_q[i].s, f_s(ANGLE_W'(exp_ang[i])));
            check($sformatf("%s_cos%0d", name, i), smp_q[i].c, f_c(ANGLE_W'(exp_ang[i])));
            check($sformatf("%s_scyc%0d", name, i), smp_q[i].cyc - s0, i + 4);
        end
        tick();
        check({name, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int s0, dcyc, dc0;
        int basic_ang[4] = '{0, 128, 256, 384};
        int wrap_ang[4]  = '{1000, 76, 176, 0};
        int exp_pcyc[4]  = '{4, 5, 8, 9};

        areset = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        start_angle = '0; step = '0; count = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_angle", angle_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_idx", sample_idx, 0);
        areset = 1'b1;
        tick();

        run_sweep("basic", 10'd0, 10'd128, 4, basic_ang);
        run_sweep("wrap", 10'd1000, 10'd100, 3, wrap_ang);

        // Zero count: done next cycle, never busy, no samples.
        smp_q.delete();
        kick(10'd5, 10'd1, 11'd0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        tick();
        check("zero_done_once", done, 0);
        repeat (6) tick();
        check("zero_nsamples", smp_q.size(), 0);

        // Pause for 2 cycles after the 2nd issue.
        smp_q.delete();
        kick(10'd0, 10'd10, 11'd4);
        s0 = cyc;
        tick(); check("pause_a0", angle_out, 0);
        tick(); check("pause_a1", angle_out, 10);
        pause = 1'b1;
        tick(); check("pause_hold0", angle_out, 10);
        tick(); check("pause_hold1", angle_out, 10);
        pause = 1'b0;
        tick(); check("pause_a2", angle_out, 20);
        tick(); check("pause_a3", angle_out, 30);
        wait_done(20, dcyc);
        check("pause_done_cyc", dcyc - s0, 10);
        check("pause_nsamples", smp_q.size(), 4);
        for (int i = 0; i < 4 && i < smp_q.size(); i++) begin
            check($sformatf("pause_idx%0d", i), smp_q[i].idx, i);
            check($sformatf("pause_scyc%0d", i), smp_q[i].cyc - s0, exp_pcyc[i]);
            check($sformatf("pause_sin%0d", i), smp_q[i].s, f_s(ANGLE_W'(10 * i)));
        end
        tick();

        // Start while busy is ignored; abort after 2 issues.
        smp_q.delete();
        dc0 = done_cnt;
        kick(10'd0, 10'd1, 11'd8);
        tick(); check("busystart_a0", angle_out, 0);
        start = 1'b1; start_angle = 10'd500; step = 10'd7; count = 11'd2;
        tick(); check("busystart_a1", angle_out, 1);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", sample_valid, 0);
        repeat (8) tick();
        check("abort_nsamples", smp_q.size(), 0);
        check("abort_no_done", done_cnt - dc0, 0);

        // Abort has priority over start in IDLE.
        start = 1'b1; abort = 1'b1; count = 11'd4;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", busy, 0);
        repeat (6) tick();
        check("abort_start_nsmp", smp_q.size(), 0);

        // Reset during DRAIN clears everything; next sweep behaves normally.
        dc0 = done_cnt;
        kick(10'd3, 10'd128, 11'd4);
        repeat (5) tick();
        areset = 1'b0;
        tick();
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_angle", angle_out, 0);
        check("mrst_valid", sample_valid, 0);
        check("mrst_sin", sample_sin, 0);
        check("mrst_cos", sample_cos, 0);
        check("mrst_idx", sample_idx, 0);
        areset = 1'b1;
        repeat (6) tick();
        check("mrst_no_done", done_cnt - dc0, 0);
        run_sweep("after_rst", 10'd0, 10'd128, 4, basic_ang);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
